// File: rtl/reaction_timer_pkg.sv
// Shared types and constants for the reaction timer display path.
// State encoding, default converter sizing and the saturated BCD value.
package reaction_timer_pkg;

    localparam logic IDLE_ENC  = 1'b0;
    localparam logic SHIFT_ENC = 1'b1;

    typedef enum logic {
        IDLE  = IDLE_ENC,
        SHIFT = SHIFT_ENC
    } state_t;

    localparam int DEF_BIN_W  = 20;
    localparam int DEF_DIGITS = 6;

    localparam logic [4*DEF_DIGITS-1:0] BCD_NINES = {DEF_DIGITS{4'h9}};

endpackage

// File: rtl/bin_to_bcd_converter_bcd_add3.sv
// Double-dabble correction cell: a nibble of 5 or more gets 3 added.
// Purely combinational, never carries into a neighbouring nibble.
module bcd_add3
    import reaction_timer_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    always_comb begin
        dout = (din >= 4'd5) ? din + 4'd3 : din;
    end

endmodule

// File: rtl/bin_to_bcd_converter.sv
// Sequential binary-to-BCD converter, one double-dabble step per clock.
// Optional saturation on overflow: define BIN2BCD_SATURATE_EN.
module bin_to_bcd_converter
    import reaction_timer_pkg::*;
#(
    parameter int BIN_W  = DEF_BIN_W,
    parameter int DIGITS = DEF_DIGITS
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic [BIN_W-1:0]      BIN,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [4*DIGITS-1:0]   BCD,
    output logic                  OVF
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(BIN_W + 1);
    localparam logic [CW-1:0] LAST = CW'(BIN_W - 1);

    state_t          state;
    logic [BIN_W-1:0] bin_q;
    logic [BW-1:0]   work;
    logic [BW-1:0]   corr;
    logic [BW-1:0]   next_work;
    logic [CW-1:0]   cnt;

    for (genvar i = 0; i < DIGITS; i++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (work[4*i +: 4]),
            .dout (corr[4*i +: 4])
        );
    end

    assign next_work = {corr[BW-2:0], bin_q[BIN_W-1]};

`ifdef BIN2BCD_SATURATE_EN
    logic carry;
    logic carry_nxt;
    // Any bit pushed out of the top digit means the value needs another digit.
    assign carry_nxt = carry | corr[BW-1];
`else
    logic unused_top;
    assign unused_top = corr[BW-1];
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            bin_q <= '0;
            work  <= '0;
            cnt   <= '0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
            BCD   <= '0;
            OVF   <= 1'b0;
`ifdef BIN2BCD_SATURATE_EN
            carry <= 1'b0;
`endif
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        bin_q <= BIN;
                        work  <= '0;
                        cnt   <= '0;
                        BUSY  <= 1'b1;
                        state <= SHIFT;
`ifdef BIN2BCD_SATURATE_EN
                        carry <= 1'b0;
`endif
                    end
                end
                SHIFT: begin
                    bin_q <= bin_q << 1;
                    work  <= next_work;
                    cnt   <= cnt + 1'b1;
`ifdef BIN2BCD_SATURATE_EN
                    carry <= carry_nxt;
`endif
                    if (cnt == LAST) begin
`ifdef BIN2BCD_SATURATE_EN
                        BCD <= carry_nxt ? {DIGITS{4'h9}} : next_work;
                        OVF <= carry_nxt;
`else
                        BCD <= next_work;
                        OVF <= 1'b0;
`endif
                        DONE  <= 1'b1;
                        BUSY  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_converter.sv
// Scoreboard bench: stimulus pushes expected results, a monitor pops on DONE.
// Reference model uses decimal arithmetic on the binary value.
module tb_bin_to_bcd_converter;

    localparam int W  = 20;
    localparam int D  = 6;
    localparam int W8 = 8;
    localparam int D8 = 3;

    logic          clk = 1'b0;
    logic          RST;
    logic          START;
    logic [W-1:0]  BIN;
    logic          BUSY, DONE, OVF;
    logic [4*D-1:0] BCD;

    logic           START8;
    logic [W8-1:0]  BIN8;
    logic           BUSY8, DONE8, OVF8;
    logic [4*D8-1:0] BCD8;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [23:0] bcd;
        logic        ovf;
        int          done_cyc;
    } exp_t;

    exp_t exp_q[$];
    logic [23:0] last_bcd;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bin_to_bcd_converter #(.BIN_W(W), .DIGITS(D)) dut (
        .CLK(clk), .RST(RST), .START(START), .BIN(BIN),
        .BUSY(BUSY), .DONE(DONE), .BCD(BCD), .OVF(OVF)
    );

    bin_to_bcd_converter #(.BIN_W(W8), .DIGITS(D8)) dut8 (
        .CLK(clk), .RST(RST), .START(START8), .BIN(BIN8),
        .BUSY(BUSY8), .DONE(DONE8), .BCD(BCD8), .OVF(OVF8)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] to_bcd(input longint v, input int digits);
        logic [23:0] r = '0;
        longint x = v;
        for (int i = 0; i < digits; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic void model(input longint v, input int digits,
                                  output logic [23:0] bcd, output logic ovf);
        longint lim = 1;
        for (int i = 0; i < digits; i++) lim = lim * 10;
`ifdef BIN2BCD_SATURATE_EN
        ovf = (v >= lim);
        bcd = ovf ? to_bcd(lim - 1, digits) : to_bcd(v, digits);
`else
        ovf = 1'b0;
        bcd = to_bcd(v % lim, digits);
`endif
    endfunction

    always @(negedge clk) begin
        if (!RST && DONE) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("bcd", 32'(BCD), 32'(e.bcd));
                chk("ovf", 32'(OVF), 32'(e.ovf));
                chk("latency", 32'(cyc), 32'(e.done_cyc));
                chk("busy_at_done", 32'(BUSY), 32'd0);
            end
        end
    end

    task automatic issue(input logic [W-1:0] b);
        int n = 0;
        exp_t e;
        while (BUSY && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (BUSY) chk("idle_timeout", 32'd1, 32'd0);
        START = 1'b1;
        BIN   = b;
        model(longint'(b), D, e.bcd, e.ovf);
        e.done_cyc = cyc + 1 + W;
        last_bcd = e.bcd;
        exp_q.push_back(e);
        @(negedge clk);
        START = 1'b0;
        BIN   = W'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(negedge clk);
    endtask

    task automatic run8(input logic [W8-1:0] b);
        int c0;
        int n = 0;
        logic [23:0] eb;
        logic eo;
        model(longint'(b), D8, eb, eo);
        START8 = 1'b1;
        BIN8   = b;
        c0 = cyc;
        @(negedge clk);
        START8 = 1'b0;
        BIN8   = W8'($urandom);
        while (!DONE8 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("done8_seen", 32'(DONE8), 32'd1);
        chk("latency8", 32'(cyc), 32'(c0 + 1 + W8));
        chk("bcd8", 32'(BCD8), 32'(eb[4*D8-1:0]));
        chk("ovf8", 32'(OVF8), 32'(eo));
        @(negedge clk);
    endtask

    initial begin
        int busy_low;
        int done_seen;
        int n;
        RST    = 1'b1;
        START  = 1'b0;
        BIN    = '0;
        START8 = 1'b0;
        BIN8   = '0;
        repeat (3) @(negedge clk);
        RST = 1'b0;
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        chk("rst_bcd", 32'(BCD), 32'd0);
        chk("rst_ovf", 32'(OVF), 32'd0);

        issue(W'(0));
        drain();

        issue(W'(123456));
        issue(W'(999999));
        drain();

        issue(W'(1048575));
        issue(W'(1000000));
        issue(W'(1));
        issue(W'(999999));
        drain();

        for (int i = 0; i < 30; i++) begin
            issue(W'($urandom_range(0, (1 << W) - 1)));
        end
        drain();
        repeat (3) @(negedge clk);
        chk("bcd_hold", 32'(BCD), 32'(last_bcd));

        issue(W'(42));
        repeat (4) @(negedge clk);
        START = 1'b1;
        BIN   = W'(777);
        chk("busy_ignored_start", 32'(BUSY), 32'd1);
        @(negedge clk);
        START = 1'b0;
        busy_low = 0;
        n = 0;
        while (!DONE && n < 40) begin
            if (!BUSY) busy_low++;
            @(negedge clk);
            n++;
        end
        chk("busy_held", 32'(busy_low), 32'd0);
        drain();
        repeat (25) @(negedge clk);
        chk("bcd_after_ignored", 32'(BCD), 32'h000042);

        issue(W'(500000));
        repeat (9) @(negedge clk);
        RST = 1'b1;
        exp_q.delete();
        @(negedge clk);
        RST = 1'b0;
        chk("abort_busy", 32'(BUSY), 32'd0);
        chk("abort_bcd", 32'(BCD), 32'd0);
        done_seen = 0;
        for (int i = 0; i < 25; i++) begin
            if (DONE) done_seen++;
            @(negedge clk);
        end
        chk("abort_no_done", 32'(done_seen), 32'd0);

        run8(W8'(255));
        run8(W8'(0));
        for (int i = 0; i < 5; i++) run8(W8'($urandom_range(0, 255)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
